// File: rtl/ringbuffer_drain_pkg.sv
// Shared definitions for the ring-buffer reader: FSM state encoding and the
// default record terminator.
package ringbuffer_drain_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LATCH   = 3'd2,
    S_SEND    = 3'd3,
    S_TERM    = 3'd4,
    S_DONE    = 3'd5,
    S_HOLDOFF = 3'd6
  } state_t;

  localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h0A;

endpackage

// File: rtl/ringbuffer_drain_sync_ff.sv
// Multi-flop synchronizer for a single cross-domain flag; RESET_VAL chooses
// the safe value presented while the chain fills after reset.
module sync_ff
  import ringbuffer_drain_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ringbuffer_drain.sv
// Reader end of the capture ring buffer: fetches one record, streams it MSB-first
// as bytes on a valid/ready port, optionally appends a terminator, pulses read_done.
module ringbuffer_drain
  import ringbuffer_drain_pkg::*;
#(
  parameter int         DATA_W      = 48,
  parameter bit         TERM_EN     = 1'b1,
  parameter logic [7:0] TERM_BYTE   = TERM_BYTE_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              read_done,
  output logic              busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int HOLD_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NBYTES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SYNC_STAGES);

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   shreg_shift_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                mem_rd_en_q;
  logic [7:0]          out_data_q;
  logic                out_valid_q;
  logic                read_done_q;
  logic                busy_q;
  logic                empty_s;

  // Reset value 1 keeps the reader from fetching until the chain has filled.
  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_empty_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (empty),
    .q_o   (empty_s)
  );

  assign shreg_shift_d = shreg_q << 8;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      mem_rd_en_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      read_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_rd_en_q <= 1'b0;
      read_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty_s) begin
            mem_rd_en_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          shreg_q     <= mem_rdata;
          out_data_q  <= mem_rdata[DATA_W-1 -: 8];
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            if (cnt_q == LAST_CNT) begin
              if (TERM_EN) begin
                out_data_q <= TERM_BYTE;
                state_q    <= S_TERM;
              end else begin
                out_valid_q <= 1'b0;
                out_data_q  <= 8'h00;
                read_done_q <= 1'b1;
                state_q     <= S_DONE;
              end
            end else begin
              shreg_q    <= shreg_shift_d;
              out_data_q <= shreg_shift_d[DATA_W-1 -: 8];
              cnt_q      <= cnt_q + 1'b1;
            end
          end
        end
        S_TERM: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            read_done_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          hold_q  <= '0;
          state_q <= S_HOLDOFF;
        end
        // Give the ring buffer's updated empty flag time to cross the sync chain.
        S_HOLDOFF: begin
          if (hold_q == HOLD_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign read_done = read_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Randomized bench with a queue-based ring-buffer model and byte scoreboard.
module tb_ringbuffer_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: 48-bit records with terminator ----------------
  logic        empty_a = 1'b1, e1_a = 1'b1;
  logic        mem_rd_en_a, out_valid_a, read_done_a, busy_a;
  logic [47:0] mem_rdata_a = '0;
  logic [7:0]  out_data_a;
  logic        out_ready_a = 1'b1;
  logic [47:0] rb_a[$];

  ringbuffer_drain #(.DATA_W(48), .TERM_EN(1'b1), .TERM_BYTE(8'h0A), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(rst_n), .empty(empty_a), .mem_rd_en(mem_rd_en_a),
    .mem_rdata(mem_rdata_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .read_done(read_done_a), .busy(busy_a));

  // Ring buffer model: RAM returns the head one cycle after the read strobe,
  // read_done pops the head, empty reaches the reader two cycles later.
  always @(posedge clk) begin
    if (mem_rd_en_a) mem_rdata_a <= (rb_a.size() > 0) ? rb_a[0] : 48'h0;
    if (read_done_a && rb_a.size() > 0) rb_a.pop_front();
    e1_a    <= (rb_a.size() == 0);
    empty_a <= e1_a;
  end

  // ---------------- DUT B: 32-bit records, no terminator ----------------
  logic        empty_b = 1'b1, e1_b = 1'b1;
  logic        mem_rd_en_b, out_valid_b, read_done_b, busy_b;
  logic [31:0] mem_rdata_b = '0;
  logic [7:0]  out_data_b;
  logic        out_ready_b = 1'b1;
  logic [31:0] rb_b[$];

  ringbuffer_drain #(.DATA_W(32), .TERM_EN(1'b0), .TERM_BYTE(8'h0A), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(rst_n), .empty(empty_b), .mem_rd_en(mem_rd_en_b),
    .mem_rdata(mem_rdata_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .read_done(read_done_b), .busy(busy_b));

  always @(posedge clk) begin
    if (mem_rd_en_b) mem_rdata_b <= (rb_b.size() > 0) ? rb_b[0] : 32'h0;
    if (read_done_b && rb_b.size() > 0) rb_b.pop_front();
    e1_b    <= (rb_b.size() == 0);
    empty_b <= e1_b;
  end

  // ---------------- out_ready pattern driver ----------------
  initial begin
    int rc = 0;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (mode)
        0:       out_ready_a = 1'b1;
        1:       out_ready_a = (rc % 3 == 0);
        default: out_ready_a = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // ---------------- scoreboard for DUT A ----------------
  logic [7:0] exp_a[$];
  logic [7:0] log_a[$];
  int         fetch_a = 0, done_a = 0, hs_a = 0;
  int         fetch_cyc[$];
  int         done_cyc[$];
  logic       rec_open = 1'b0, pv = 1'b0, pr = 1'b0, prd = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] lb_b[$];
  int         done_b = 0;

  always @(negedge clk) begin
    logic [47:0] rec;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {out_data_a, mem_rd_en_a, out_valid_a, read_done_a, busy_a}, 0);
      exp_a.delete();
      rec_open = 1'b0;
      pv = 1'b0;
      prd = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", out_valid_a, 1);
        chk("hold_data", out_data_a, pd);
      end
      if (mem_rd_en_a || out_valid_a || read_done_a) chk("busy_active", busy_a, 1);
      if (mem_rd_en_a) begin
        fetch_a++;
        fetch_cyc.push_back(cyc);
        chk("fetch_nonempty", rb_a.size() != 0, 1);
        chk("fetch_no_overlap", rec_open, 0);
        rec_open = 1'b1;
        rec = (rb_a.size() != 0) ? rb_a[0] : 48'h0;
        for (int i = 0; i < 6; i++) exp_a.push_back(rec[47-8*i -: 8]);
        exp_a.push_back(8'h0A);
      end
      if (out_valid_a && out_ready_a) begin
        hs_a++;
        log_a.push_back(out_data_a);
        chk("byte_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) chk("byte_value", out_data_a, exp_a.pop_front());
      end
      if (read_done_a) begin
        done_a++;
        done_cyc.push_back(cyc);
        chk("done_after_bytes", exp_a.size(), 0);
        chk("done_has_fetch", rec_open, 1);
        chk("done_one_cycle", prd, 0);
        rec_open = 1'b0;
      end
      pv  = out_valid_a;
      pr  = out_ready_a;
      pd  = out_data_a;
      prd = read_done_a;
    end
    if (rst_n && out_valid_b && out_ready_b) lb_b.push_back(out_data_b);
    if (rst_n && read_done_b) done_b++;
  end

  task automatic wait_done_a(input int target, input int budget);
    int n = 0;
    while (done_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_a", done_a >= target, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_log_a(input string name);
    logic [7:0] lit [7] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h0A};
    chk({name, "_len"}, log_a.size(), 7);
    for (int i = 0; i < 7; i++) chk(name, (i < log_a.size()) ? log_a[i] : 8'hxx, lit[i]);
  endtask

  initial begin
    int base_done, base_fetch, base_hs, n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: empty held high, reader must stay quiet
    repeat (100) begin
      @(negedge clk);
      chk("idle_quiet", {mem_rd_en_a, out_valid_a, read_done_a}, 0);
      chk("idle_busy", busy_a, 0);
    end

    // 2: single record, always ready
    @(posedge clk); #1;
    log_a.delete();
    rb_a.push_back(48'h0123456789AB);
    wait_done_a(1, 200);
    check_log_a("single_bytes");
    chk("single_done_count", done_a, 1);
    chk("fetch_to_done_latency", done_cyc[0] - fetch_cyc[0], 9);
    chk("idle_after_record", busy_a, 0);

    // 3: backpressure, ready one cycle in three
    mode = 1;
    @(posedge clk); #1;
    log_a.delete();
    rb_a.push_back(48'h0123456789AB);
    wait_done_a(2, 400);
    check_log_a("backpressure_bytes");

    // 4: three queued records back to back
    mode = 0;
    @(posedge clk); #1;
    base_done = done_a;
    base_fetch = fetch_a;
    for (int i = 0; i < 3; i++) rb_a.push_back({$urandom(), 16'($urandom())});
    wait_done_a(base_done + 3, 300);
    repeat (40) @(negedge clk);
    chk("b2b_done_count", done_a - base_done, 3);
    chk("b2b_fetch_count", fetch_a - base_fetch, 3);
    chk("b2b_interval0", fetch_cyc[base_fetch+1] - fetch_cyc[base_fetch], 14);
    chk("b2b_interval1", fetch_cyc[base_fetch+2] - fetch_cyc[base_fetch+1], 14);

    // randomized: records and random ready, scoreboard checks every byte
    mode = 2;
    for (int r = 0; r < 10; r++) begin
      @(posedge clk); #1;
      base_done = done_a;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) rb_a.push_back({$urandom(), 16'($urandom())});
      wait_done_a(base_done + n, 200 * n);
      repeat ($urandom_range(0, 10)) @(posedge clk);
    end

    // 5: reset after third byte, record must be resent whole
    mode = 0;
    @(posedge clk); #1;
    base_done = done_a;
    base_hs = hs_a;
    rb_a.push_back(48'h0123456789AB);
    n = 0;
    while (hs_a < base_hs + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reset_wait_bytes", hs_a >= base_hs + 3, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", {out_data_a, out_valid_a, mem_rd_en_a, read_done_a, busy_a}, 0);
    repeat (3) @(posedge clk);
    chk("reset_no_done", done_a, base_done);
    chk("reset_record_kept", rb_a.size(), 1);
    #1 rst_n = 1'b1;
    log_a.delete();
    wait_done_a(base_done + 1, 200);
    check_log_a("resent_bytes");

    // 6: 32-bit, no terminator
    @(posedge clk); #1;
    lb_b.delete();
    done_b = 0;
    rb_b.push_back(32'hDEADBEEF);
    n = 0;
    while (done_b < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk("b_done_count", done_b, 1);
    chk("b_len", lb_b.size(), 4);
    begin
      logic [7:0] litb [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int i = 0; i < 4; i++) chk("b_bytes", (i < lb_b.size()) ? lb_b[i] : 8'hxx, litb[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
